// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Lock FSM states, requester indices and the address legality check.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED0  = 2'd1,
    ST_LOCKED1  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_t;

  function automatic req_t other(input req_t r);
    return (r == REQ_M0) ? REQ_M1 : REQ_M0;
  endfunction

  // Word aligned and word index inside the memory.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick with an optional single-requester lock mask.
// Produces a one-hot (or zero) grant in the same cycle.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       lock_en,
  input  logic       lock_id,
  output logic [1:0] grant
);

  logic [1:0] elig;

  always_comb begin
    elig = valid;
    if (lock_en) begin
      elig = valid & (lock_id ? 2'b10 : 2'b01);
    end
    grant = elig;
    if (elig == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (m0) and a debug/DMA loader (m1).
// Round-robin grant, lock with timeout, registered one-cycle response per requester.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  state_t        state, state_nx;
  req_t          ptr, ptr_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [1:0]  grant;
  logic        fire, expire, lock_en, ok;
  req_t        win, owner;
  logic        sel_we, sel_lock;
  logic [31:0] sel_addr, sel_wdata, resp_data;

  assign owner   = (state == ST_LOCKED1) ? REQ_M1 : REQ_M0;
  // At the timeout count the mask is already lifted so the other side can win this cycle.
  assign expire  = (state != ST_UNLOCKED) && (cnt == CW'(LOCK_MAX));
  assign lock_en = (state != ST_UNLOCKED) && !expire;

  rr_arb2 u_rr_arb2 (
    .valid   ({m1_valid, m0_valid}),
    .ptr     (ptr),
    .lock_en (lock_en),
    .lock_id (owner),
    .grant   (grant)
  );

  assign m0_ready = grant[0];
  assign m1_ready = grant[1];
  assign fire     = |grant;
  assign win      = grant[1] ? REQ_M1 : REQ_M0;

  assign sel_we    = (win == REQ_M1) ? m1_we    : m0_we;
  assign sel_addr  = (win == REQ_M1) ? m1_addr  : m0_addr;
  assign sel_wdata = (win == REQ_M1) ? m1_wdata : m0_wdata;
  assign sel_lock  = (win == REQ_M1) ? m1_lock  : m0_lock;
  assign ok        = addr_ok(sel_addr, DEPTH);

  assign mem_we    = fire & sel_we & ok;
  assign mem_a     = fire ? sel_addr  : '0;
  assign mem_wd    = fire ? sel_wdata : '0;
  assign resp_data = (ok && !sel_we) ? mem_rd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_UNLOCKED;
      ptr   <= REQ_M0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    if (lock_en) begin
      if (fire && !sel_lock) begin
        state_nx = ST_UNLOCKED;
        ptr_nx   = other(win);
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end else begin
      // Expiry cycle behaves like an unlocked cycle; a fire here may take a fresh lock.
      if (expire) begin
        state_nx = ST_UNLOCKED;
        ptr_nx   = other(owner);
        cnt_nx   = '0;
      end
      if (fire) begin
        ptr_nx = other(win);
        if (sel_lock) begin
          state_nx = (win == REQ_M1) ? ST_LOCKED1 : ST_LOCKED0;
          cnt_nx   = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      m0_rvalid <= fire && (win == REQ_M0);
      m1_rvalid <= fire && (win == REQ_M1);
      if (fire && (win == REQ_M0)) begin
        m0_rdata <= resp_data;
        m0_err   <= !ok;
      end
      if (fire && (win == REQ_M1)) begin
        m1_rdata <= resp_data;
        m1_err   <= !ok;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_ready, m0_we, m0_lock, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_valid, m1_ready, m1_we, m1_lock, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory the DUT drives: asynchronous read, synchronous write.
  function automatic logic [31:0] init_word(input int unsigned i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] env_mem [64];
  logic        tb_init = 1'b0;
  assign mem_rd = env_mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_word(i);
    end else if (mem_we) begin
      env_mem[mem_a[7:2]] <= mem_wd;
    end
  end

  int passed = 0;
  int total  = 0;

  // Reference model state: who holds the lock, how long, whose turn it is.
  logic [31:0] ref_mem [64];
  int          m_owner = -1;
  int          m_age   = 0;
  int          m_ptr   = 0;
  int          exp_win;
  logic        e_we, e_ok, e_lock;
  logic [31:0] e_a, e_wd;
  logic        exp_mwe;
  logic [31:0] exp_ma, exp_mwd;
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  logic        exp_err [2];

  logic        obs_rdy0, obs_rdy1, obs_mwe, obs_rv0, obs_rv1, obs_err0, obs_err1;
  logic [31:0] obs_ma, obs_mwd, obs_rd0, obs_rd1;

  task automatic model_eval();
    bit lk, c0, c1;
    lk = (m_owner >= 0) && (m_age < LOCK_MAX);
    c0 = m0_valid && (!lk || m_owner == 0);
    c1 = m1_valid && (!lk || m_owner == 1);
    if (c0 && c1) exp_win = m_ptr;
    else if (c0)  exp_win = 0;
    else if (c1)  exp_win = 1;
    else          exp_win = -1;
    e_a    = (exp_win == 1) ? m1_addr  : m0_addr;
    e_wd   = (exp_win == 1) ? m1_wdata : m0_wdata;
    e_we   = (exp_win == 1) ? m1_we    : m0_we;
    e_lock = (exp_win == 1) ? m1_lock  : m0_lock;
    e_ok   = (e_a % 4 == 0) && (e_a / 4 < DEPTH);
    exp_mwe = (exp_win >= 0) && e_we && e_ok;
    exp_ma  = (exp_win >= 0) ? e_a  : 32'd0;
    exp_mwd = (exp_win >= 0) ? e_wd : 32'd0;
  endtask

  task automatic model_commit();
    if (reset) begin
      m_owner = -1; m_age = 0; m_ptr = 0;
      for (int i = 0; i < 2; i++) begin
        exp_rv[i] = 1'b0; exp_rd[i] = '0; exp_err[i] = 1'b0;
      end
    end else begin
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      if (exp_win >= 0) begin
        exp_rv[exp_win]  = 1'b1;
        exp_err[exp_win] = !e_ok;
        exp_rd[exp_win]  = (e_ok && !e_we) ? ref_mem[e_a / 4] : 32'd0;
        if (e_ok && e_we) ref_mem[e_a / 4] = e_wd;
      end
      if (m_owner >= 0 && m_age < LOCK_MAX) begin
        if (exp_win >= 0 && !e_lock) begin
          m_owner = -1; m_age = 0; m_ptr = 1 - exp_win;
        end else begin
          m_age++;
        end
      end else begin
        if (m_owner >= 0) begin
          m_ptr = 1 - m_owner; m_owner = -1; m_age = 0;
        end
        if (exp_win >= 0) begin
          m_ptr = 1 - exp_win;
          if (e_lock) begin
            m_owner = exp_win; m_age = 1;
          end
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; combinational outputs sampled 1 ns later,
  // registered outputs 1 ns after the rising edge.
  task automatic tick();
    #1;
    model_eval();
    obs_rdy0 = m0_ready; obs_rdy1 = m1_ready;
    obs_mwe = mem_we; obs_ma = mem_a; obs_mwd = mem_wd;
    @(posedge clk);
    model_commit();
    #1;
    obs_rv0 = m0_rvalid; obs_rd0 = m0_rdata; obs_err0 = m0_err;
    obs_rv1 = m1_rvalid; obs_rd1 = m1_rdata; obs_err1 = m1_err;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
    m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; tb_init = 1;
    tick();
    tb_init = 0;
    tick();
    reset = 0;
    tick();
    total++; if (obs_rv0 === 1'b0 && obs_rv1 === 1'b0) passed++;
    else $display("FAIL reset_rvalid got %b%b want 00", obs_rv0, obs_rv1);
    total++; if (obs_rd0 === 32'd0 && obs_rd1 === 32'd0 && obs_err0 === 1'b0 && obs_err1 === 1'b0) passed++;
    else $display("FAIL reset_rdata got %h/%h err %b%b want 0", obs_rd0, obs_rd1, obs_err0, obs_err1);
    total++; if (obs_rdy0 === 1'b0 && obs_rdy1 === 1'b0 && obs_mwe === 1'b0 && obs_ma === 32'd0) passed++;
    else $display("FAIL reset_idle got rdy %b%b we %b a %h want 0", obs_rdy0, obs_rdy1, obs_mwe, obs_ma);
  endtask

  task automatic test_write_read();
    m0_valid = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
    tick();
    total++; if (obs_rdy0 === 1'b1 && obs_mwe === 1'b1 && obs_ma === 32'h10 && obs_mwd === 32'hDEAD_BEEF) passed++;
    else $display("FAIL wr_issue got rdy %b we %b a %h wd %h", obs_rdy0, obs_mwe, obs_ma, obs_mwd);
    total++; if (obs_rv0 === 1'b1 && obs_rd0 === 32'd0 && obs_err0 === 1'b0) passed++;
    else $display("FAIL wr_resp got rv %b rd %h err %b want 1 0 0", obs_rv0, obs_rd0, obs_err0);
    m0_we = 0; m0_wdata = 0;
    tick();
    total++; if (obs_rdy0 === 1'b1 && obs_rv0 === 1'b1 && obs_rd0 === 32'hDEAD_BEEF && obs_err0 === 1'b0) passed++;
    else $display("FAIL rd_resp got rdy %b rv %b rd %h err %b want 1 1 deadbeef 0", obs_rdy0, obs_rv0, obs_rd0, obs_err0);
    idle_inputs();
    tick();
    total++; if (obs_rv0 === 1'b0 && obs_rd0 === 32'hDEAD_BEEF) passed++;
    else $display("FAIL rd_hold got rv %b rd %h want 0 deadbeef", obs_rv0, obs_rd0);
  endtask

  task automatic test_contention();
    do_reset();
    m0_valid = 1; m0_addr = 32'h24;
    m1_valid = 1; m1_addr = 32'h28;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (obs_rdy0 === (i % 2 == 0) && obs_rdy1 === (i % 2 == 1)) passed++;
      else $display("FAIL rr_grant%0d got %b%b", i, obs_rdy1, obs_rdy0);
      total++; if (obs_rv0 === (i % 2 == 0) && obs_rv1 === (i % 2 == 1)
                   && obs_rd0 === exp_rd[0] && obs_rd1 === exp_rd[1]) passed++;
      else $display("FAIL rr_resp%0d got rv %b%b rd %h/%h want %h/%h", i, obs_rv1, obs_rv0,
                    obs_rd0, obs_rd1, exp_rd[0], exp_rd[1]);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    m1_valid = 1; m1_addr = 32'h40;
    m0_valid = 1; m0_we = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h20 + 32'(4 * i); m0_wdata = $urandom; m0_lock = (i < 3);
      tick();
      total++; if (obs_rdy0 === 1'b1 && obs_rdy1 === 1'b0) passed++;
      else $display("FAIL lock_hold%0d got rdy0 %b rdy1 %b want 1 0", i, obs_rdy0, obs_rdy1);
    end
    m0_addr = 32'h30; m0_lock = 0;
    tick();
    total++; if (obs_rdy1 === 1'b1 && obs_rdy0 === 1'b0) passed++;
    else $display("FAIL lock_release got rdy0 %b rdy1 %b want 0 1", obs_rdy0, obs_rdy1);
    idle_inputs();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    m1_valid = 1; m1_addr = 32'h8; m1_lock = 1;
    tick();
    total++; if (obs_rdy1 === 1'b1) passed++;
    else $display("FAIL to_lock got rdy1 %b want 1", obs_rdy1);
    idle_inputs();
    m0_valid = 1; m0_we = 1; m0_addr = 32'h34; m0_wdata = 32'h1234_5678;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++; if (obs_rdy0 === (i == 16)) passed++;
      else $display("FAIL to_wait%0d got rdy0 %b want %b", i, obs_rdy0, (i == 16));
    end
    total++; if (obs_rv0 === 1'b1 && obs_err0 === 1'b0) passed++;
    else $display("FAIL to_resp got rv %b err %b want 1 0", obs_rv0, obs_err0);
    m0_we = 0; m1_valid = 1; m1_lock = 0;
    tick();
    total++; if (obs_rdy1 === 1'b1 && obs_rdy0 === 1'b0) passed++;
    else $display("FAIL to_after got rdy0 %b rdy1 %b want 0 1", obs_rdy0, obs_rdy1);
    idle_inputs();
  endtask

  task automatic test_bad_addr();
    logic [31:0] saved;
    saved = ref_mem[0];
    m0_valid = 1; m0_we = 1; m0_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      m0_addr = (i == 0) ? 32'h102 : 32'h100;
      tick();
      total++; if (obs_rdy0 === 1'b1 && obs_mwe === 1'b0) passed++;
      else $display("FAIL bad_we%0d got rdy %b we %b want 1 0", i, obs_rdy0, obs_mwe);
      total++; if (obs_rv0 === 1'b1 && obs_err0 === 1'b1 && obs_rd0 === 32'd0) passed++;
      else $display("FAIL bad_resp%0d got rv %b err %b rd %h want 1 1 0", i, obs_rv0, obs_err0, obs_rd0);
    end
    m0_we = 0; m0_addr = 32'h0;
    tick();
    total++; if (obs_err0 === 1'b0 && obs_rd0 === saved && env_mem[0] === saved) passed++;
    else $display("FAIL bad_clear got err %b rd %h mem %h want 0 %h", obs_err0, obs_rd0, env_mem[0], saved);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_valid = 1; m1_addr = 32'h4; m1_lock = 1;
    tick();
    m1_addr = 32'h8;
    reset = 1;
    tick();
    reset = 0;
    total++; if (obs_rdy1 === 1'b1 && obs_rv1 === 1'b0 && obs_rd1 === 32'd0) passed++;
    else $display("FAIL rst_drop got rdy1 %b rv1 %b rd1 %h want 1 0 0", obs_rdy1, obs_rv1, obs_rd1);
    m1_lock = 0; m0_valid = 1; m0_addr = 32'hC;
    tick();
    total++; if (obs_rdy0 === 1'b1 && obs_rdy1 === 1'b0 && obs_rv0 === 1'b1) passed++;
    else $display("FAIL rst_state got rdy %b%b rv0 %b want 01 1", obs_rdy1, obs_rdy0, obs_rv0);
    idle_inputs();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 70)) * 32'd4;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic test_random();
    bit pend0, pend1;
    int errs;
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend0) begin
        m0_valid = ($urandom_range(0, 9) < 7); m0_we = $urandom_range(0, 1);
        m0_addr = rand_addr(); m0_wdata = $urandom; m0_lock = ($urandom_range(0, 3) == 0);
      end
      if (!pend1) begin
        m1_valid = ($urandom_range(0, 9) < 7); m1_we = $urandom_range(0, 1);
        m1_addr = rand_addr(); m1_wdata = $urandom; m1_lock = ($urandom_range(0, 3) == 0);
      end
      tick();
      errs = 0;
      if (obs_rdy0 !== (exp_win == 0) || obs_rdy1 !== (exp_win == 1)) errs++;
      if (obs_mwe !== exp_mwe || obs_ma !== exp_ma || obs_mwd !== exp_mwd) errs++;
      if (obs_rv0 !== exp_rv[0] || obs_rd0 !== exp_rd[0] || obs_err0 !== exp_err[0]) errs++;
      if (obs_rv1 !== exp_rv[1] || obs_rd1 !== exp_rd[1] || obs_err1 !== exp_err[1]) errs++;
      total++;
      if (errs == 0) passed++;
      else $display("FAIL rand%0d got rdy %b%b we %b a %h rv %b%b rd %h/%h err %b%b want win %0d we %b a %h rv %b%b rd %h/%h err %b%b",
                    c, obs_rdy1, obs_rdy0, obs_mwe, obs_ma, obs_rv1, obs_rv0, obs_rd0, obs_rd1,
                    obs_err1, obs_err0, exp_win, exp_mwe, exp_ma, exp_rv[1], exp_rv[0],
                    exp_rd[0], exp_rd[1], exp_err[1], exp_err[0]);
      pend0 = m0_valid && (exp_win != 0);
      pend1 = m1_valid && (exp_win != 1);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 2; i++) begin
      exp_rv[i] = 1'b0; exp_rd[i] = '0; exp_err[i] = 1'b0;
    end
    idle_inputs();
    reset = 1;
    test_reset();
    test_write_read();
    test_contention();
    test_lock();
    test_lock_timeout();
    test_bad_addr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
